// File: rtl/imm_ext_sequencer.sv
// Two-stage immediate/branch-target generator for the MIPS execute path.
// Stage 1 decodes the opcode into an extension kind; stage 2 forms imm32 and br_target.
module imm_ext_sequencer #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          ILLEGAL_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      imm32,
  output logic [31:0]      br_target,
  output logic             sign_ext_o,
  output logic             is_branch,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    EXT_ZERO,
    EXT_SIGN,
    EXT_LUI,
    EXT_ILL
  } ext_kind_e;

  // Stage 1 state
  logic        v1_q, v1_d;
  ext_kind_e   kind1_q, kind1_d;
  logic        isbr1_q, isbr1_d;
  logic [15:0] imm1_q, imm1_d;
  logic [29:0] pcw1_q, pcw1_d;

  // Stage 2 state
  logic        v2_q, v2_d;
  logic [31:0] imm32_q, imm32_d;
  logic [31:0] br_q, br_d;
  logic        sext_q, sext_d;
  logic        isbr_q, isbr_d;
  logic        ill_q, ill_d;

  logic [CNT_W-1:0] ret_q, ret_d;

  logic      rdy1, rdy2;
  logic      accept, advance, retire;
  ext_kind_e kind_dec;
  logic      isbr_dec;
  logic [29:0] off30;
  logic      unused_bits;

  assign unused_bits = ^{instr[25:16], pc[1:0]};

  assign rdy2     = !v2_q || out_ready;
  assign rdy1     = !v1_q || rdy2;
  assign in_ready = rdy1;
  // flush blocks the accept but leaves in_ready as the plain pipeline ready
  assign accept   = in_valid && rdy1 && !flush;
  assign advance  = v1_q && rdy2;
  assign retire   = v2_q && out_ready;

  always_comb begin
    kind_dec = EXT_ILL;
    isbr_dec = 1'b0;
    unique case (instr[31:26])
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b100011, 6'b101011:          kind_dec = EXT_SIGN;
      6'b000100, 6'b000101: begin
        kind_dec = EXT_SIGN;
        isbr_dec = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: kind_dec = EXT_ZERO;
      6'b001111:                     kind_dec = EXT_LUI;
      default:                       kind_dec = EXT_ILL;
    endcase
  end

  always_comb begin
    v1_d    = v1_q;
    kind1_d = kind1_q;
    isbr1_d = isbr1_q;
    imm1_d  = imm1_q;
    pcw1_d  = pcw1_q;
    if (flush) begin
      v1_d = 1'b0;
    end else if (accept) begin
      v1_d    = 1'b1;
      kind1_d = kind_dec;
      isbr1_d = isbr_dec;
      imm1_d  = instr[15:0];
      pcw1_d  = pc[31:2];
    end else if (advance) begin
      v1_d = 1'b0;
    end
  end

  always_comb begin
    sext_d = (kind1_q == EXT_SIGN);
    off30  = sext_d ? {{14{imm1_q[15]}}, imm1_q} : {14'h0, imm1_q};
    unique case (kind1_q)
      EXT_SIGN: imm32_d = {{16{imm1_q[15]}}, imm1_q};
      EXT_ZERO: imm32_d = {16'h0, imm1_q};
      EXT_LUI:  imm32_d = {imm1_q, 16'h0};
      default:  imm32_d = ILLEGAL_ZERO ? '0 : {16'h0, imm1_q};
    endcase
    br_d   = {pcw1_q + 30'd1 + off30, 2'b00};
    isbr_d = isbr1_q;
    ill_d  = (kind1_q == EXT_ILL);
    v2_d   = flush ? 1'b0 : (rdy2 ? v1_q : v2_q);
    ret_d  = retire ? ret_q + CNT_W'(1) : ret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      kind1_q <= EXT_ZERO;
      isbr1_q <= 1'b0;
      imm1_q  <= '0;
      pcw1_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      kind1_q <= kind1_d;
      isbr1_q <= isbr1_d;
      imm1_q  <= imm1_d;
      pcw1_q  <= pcw1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      imm32_q <= '0;
      br_q    <= '0;
      sext_q  <= 1'b0;
      isbr_q  <= 1'b0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      v2_q  <= v2_d;
      ret_q <= ret_d;
      if (advance) begin
        imm32_q <= imm32_d;
        br_q    <= br_d;
        sext_q  <= sext_d;
        isbr_q  <= isbr_d;
        ill_q   <= ill_d;
      end
    end
  end

  assign out_valid  = v2_q;
  assign imm32      = imm32_q;
  assign br_target  = br_q;
  assign sign_ext_o = sext_q;
  assign is_branch  = isbr_q;
  assign illegal    = ill_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_imm_ext_sequencer.sv
// Self-checking bench for imm_ext_sequencer: directed scenarios plus a randomized
// run scored against an arithmetic reference model.
module tb_imm_ext_sequencer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instr = '0;
  logic [31:0]   pc = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   imm32;
  logic [31:0]   br_target;
  logic          sign_ext_o;
  logic          is_branch;
  logic          illegal;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] br;
    logic        sext;
    logic        isbr;
    logic        ill;
  } res_t;

  imm_ext_sequencer #(.CNT_W(CW), .ILLEGAL_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .imm32(imm32), .br_target(br_target),
    .sign_ext_o(sign_ext_o), .is_branch(is_branch), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] ins, input logic [31:0] p);
    res_t r;
    logic [5:0]  op = ins[31:26];
    logic [31:0] z  = {16'h0, ins[15:0]};
    logic [31:0] s  = 32'($signed(ins[15:0]));
    r = '0;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05: begin
        r.sext = 1'b1;
        r.imm  = s;
      end
      6'h0C, 6'h0D, 6'h0E: r.imm = z;
      6'h0F:               r.imm = z << 16;
      default: begin
        r.ill = 1'b1;
        r.imm = '0;
      end
    endcase
    r.isbr = (op == 6'h04) || (op == 6'h05);
    r.br   = (p & 32'hFFFF_FFFC) + 32'd4 + ((r.sext ? s : z) << 2);
    return r;
  endfunction

  // Sends one instruction into an empty pipe and captures the first result.
  task automatic run_single(input logic [31:0] ins, input logic [31:0] p,
                            output res_t got, output int lat);
    in_valid = 1'b1; instr = ins; pc = p; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    got = '{imm: imm32, br: br_target, sext: sign_ext_o, isbr: is_branch, ill: illegal};
    if (out_valid) exp_ret++;
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, imm32, br_target, sign_ext_o, is_branch, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b imm=%h br=%h se=%b br=%b ill=%b ret=%0d exp all zero",
               out_valid, imm32, br_target, sign_ext_o, is_branch, illegal, retired);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
  endtask

  task automatic test_addi();
    res_t got;
    int lat;
    run_single(32'h2008FFFC, 32'h0040_0000, got, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL addi_latency got %0d exp 2", lat); end
    checks++;
    if (got.imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL addi_imm got %h exp fffffffc", got.imm); end
    checks++;
    if (got.sext !== 1'b1 || got.ill !== 1'b0) begin
      errors++; $display("FAIL addi_flags got se=%b ill=%b exp se=1 ill=0", got.sext, got.ill);
    end
    checks++;
    if (retired !== CW'(1)) begin errors++; $display("FAIL addi_retired got %0d exp 1", retired); end
  endtask

  task automatic test_ext_modes();
    res_t got;
    int lat;
    run_single(32'h34088001, 32'h0000_1000, got, lat);
    checks++;
    if (got.imm !== 32'h0000_8001 || got.sext !== 1'b0) begin
      errors++; $display("FAIL ori_zext got imm=%h se=%b exp imm=00008001 se=0", got.imm, got.sext);
    end
    run_single(32'h3C081234, 32'h0000_1004, got, lat);
    checks++;
    if (got.imm !== 32'h1234_0000 || got.sext !== 1'b0 || got.ill !== 1'b0) begin
      errors++; $display("FAIL lui_upper got imm=%h se=%b ill=%b exp imm=12340000 se=0 ill=0",
                         got.imm, got.sext, got.ill);
    end
  endtask

  task automatic test_branch();
    res_t got;
    int lat;
    run_single(32'h1000FFFF, 32'h0040_0010, got, lat);
    checks++;
    if (got.isbr !== 1'b1 || got.br !== 32'h0040_0010) begin
      errors++; $display("FAIL beq_back got isbr=%b br=%h exp isbr=1 br=00400010", got.isbr, got.br);
    end
    run_single(32'h10000000, 32'hFFFF_FFFC, got, lat);
    checks++;
    if (got.br !== 32'h0000_0000) begin
      errors++; $display("FAIL beq_wrap got br=%h exp 00000000", got.br);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    int sent = 0;
    int base = exp_ret;
    logic acc, ret;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 4);
      instr     = 32'h2008_0000 | 32'(sent + 1);
      pc        = 32'h0000_2000;
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (cyc >= 2 && cyc < 6) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || imm32 !== 32'd1 || sent != 2) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got rdy=%b ov=%b imm=%h sent=%0d exp rdy=0 ov=1 imm=1 sent=2",
                   cyc, in_ready, out_valid, imm32, sent);
        end
      end
      if (cyc == 6) begin
        checks++;
        if (!(acc && ret)) begin
          errors++; $display("FAIL pass_through got acc=%b ret=%b exp 1 1", acc, ret);
        end
      end
      if (ret) begin got.push_back(imm32); exp_ret++; end
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d exp 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin
        errors++; $display("FAIL b2b_order idx=%0d got %h exp %h", i, got[i], 32'(i + 1));
      end
    end
    checks++;
    if (retired !== CW'(base + 4)) begin
      errors++; $display("FAIL b2b_retired got %0d exp %0d", retired, CW'(base + 4));
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = 32'h2008_0100 | 32'(i); pc = 32'h100;
      @(negedge clk);
    end
    in_valid = 1'b1; instr = 32'h2008_0777; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_kill cyc=%0d got ov=%b exp 0", i, out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (retired !== CW'(exp_ret)) begin
      errors++; $display("FAIL flush_retired got %0d exp %0d", retired, CW'(exp_ret));
    end
    // flush coinciding with a live output handshake still retires it
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = 32'h2008_0200 | 32'(i); pc = 32'h200;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    if (out_valid) exp_ret++;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || retired !== CW'(exp_ret)) begin
      errors++; $display("FAIL flush_with_retire got ov=%b ret=%0d exp ov=0 ret=%0d",
                         out_valid, retired, CW'(exp_ret));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    res_t got;
    int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = 32'h2008_0005; pc = 32'h300;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, imm32, br_target, sign_ext_o, is_branch, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL async_reset got ov=%b imm=%h br=%h se=%b isbr=%b ill=%b ret=%0d exp all zero",
               out_valid, imm32, br_target, sign_ext_o, is_branch, illegal, retired);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    run_single(32'hFC00_0000, 32'h0000_4000, got, lat);
    checks++;
    if (lat !== 2 || got.ill !== 1'b1 || got.imm !== 32'h0 || got.sext !== 1'b0 || got.isbr !== 1'b0) begin
      errors++; $display("FAIL illegal_after_reset got lat=%0d ill=%b imm=%h se=%b exp lat=2 ill=1 imm=0 se=0",
                         lat, got.ill, got.imm, got.sext);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B,
                            6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    res_t q[$];
    res_t e;
    logic acc, ret;
    logic [5:0] op;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= 300 && q.size() == 0) break;
      if (cyc < 300) begin
        op        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        instr     = {op, 26'($urandom)};
        pc        = $urandom;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      checks++;
      if (in_ready !== (q.size() < 2 || out_ready)) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d got %b occ=%0d", cyc, in_ready, q.size());
      end
      if (ret) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc=%0d got output with empty model", cyc);
        end else begin
          e = q.pop_front();
          if ({imm32, br_target, sign_ext_o, is_branch, illegal} !== e) begin
            errors++;
            $display("FAIL rand_result cyc=%0d got imm=%h br=%h se=%b isbr=%b ill=%b exp imm=%h br=%h se=%b isbr=%b ill=%b",
                     cyc, imm32, br_target, sign_ext_o, is_branch, illegal, e.imm, e.br, e.sext, e.isbr, e.ill);
          end
        end
        exp_ret++;
      end
      if (acc) q.push_back(model(instr, pc));
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d left exp 0", q.size()); end
    checks++;
    if (retired !== CW'(exp_ret)) begin
      errors++; $display("FAIL rand_retired_wrap got %0d exp %0d", retired, CW'(exp_ret));
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ext_modes();
    test_branch();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_sequencer.md
Name: imm_ext_sequencer

Overview:
Two-stage pipelined immediate-generation controller for the MIPS execute path. It decodes the opcode of each incoming instruction and decides the extension mode (sign, zero, or LUI upper placement). It then drives the 32-bit immediate and the 30-bit word-offset branch-target arithmetic. A valid/ready handshake on both sides lets the decode stage feed it and the ALU/branch unit stall it; a flush input clears in-flight entries on a mispredict.

Parameters:
CNT_W, 16, width of the retired-instruction counter
ILLEGAL_ZERO, 1, 1: unsupported opcodes produce imm32=0; 0: zero-extend as for ORI

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instr/pc valid from decode
in_ready  output  1  stage 1 can accept this cycle
instr  input  32  instruction word; [31:26] opcode, [15:0] imm16
pc  input  32  byte address of instr
flush  input  1  synchronous kill of all in-flight entries
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
imm32  output  32  extended immediate
br_target  output  32  pc+4+(sext(imm16)<<2)
sign_ext_o  output  1  extension mode applied
is_branch  output  1  opcode is BEQ/BNE
illegal  output  1  opcode outside the supported set
retired  output  CNT_W  count of out_valid&&out_ready handshakes, wraps

Behaviour:
- Reset (async, rst=1): both stage valids=0, out_valid=0, imm32=0, br_target=0, sign_ext_o=0, is_branch=0, illegal=0, retired=0. Reset mid-operation drops in-flight data with no output handshake.
- Decode in stage 1 (registered on accept):
  - Sign-extend: 001000 ADDI, 001001 ADDIU, 001010 SLTI, 001011 SLTIU, 100011 LW, 101011 SW, 000100 BEQ, 000101 BNE.
  - Zero-extend: 001100 ANDI, 001101 ORI, 001110 XORI.
  - 001111 LUI: imm32={imm16,16'h0}, sign_ext_o=0.
  - Any other opcode: illegal=1, sign_ext_o=0, imm32 per ILLEGAL_ZERO.
  - is_branch=1 only for BEQ/BNE.
- Stage 2 (registered):
  - imm32 = sign_ext ? {{16{imm16[15]}},imm16} : {16'h0,imm16}, with the LUI/illegal overrides above.
  - Word offset off30 = sign_ext ? {{14{imm16[15]}},imm16} : {14'h0,imm16}.
  - br_target = {(pc[31:2] + 30'd1 + off30) mod 2^30, 2'b00}; pc[1:0] ignored.
  - br_target is computed for every opcode; it is meaningful only when is_branch=1.
- Handshake:
  - Stage k ready = !valid_k || ready_{k+1}; stage 2's downstream ready is out_ready; in_ready = stage-1 ready.
  - Transfer occurs only on valid&&ready.
  - Outputs hold stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - Accept at edge N gives out_valid at edge N+2 when unstalled.
  - Throughput is 1 per cycle; capacity is 2 entries; order is strictly preserved.
  - Combinational paths: in_ready depends on out_ready. There is no combinational path from in_valid to out_valid.
- flush:
  - At the next edge both valids clear; out_valid=0 the following cycle.
  - A simultaneous in_valid is not accepted (flush wins).
  - A simultaneous out_ready handshake still counts as retired.
  - Data registers need not clear.
- retired increments by 1 per output handshake and wraps 2^CNT_W-1 -> 0.
- Simultaneous accept-in and retire-out in a full pipe is a legal pass-through with no bubble.

Test Plan:
1. instr=0x2008FFFC (ADDI, imm -4), pc=0x00400000, out_ready=1 -> 2 cycles later out_valid=1, imm32=0xFFFFFFFC, sign_ext_o=1, illegal=0, retired=1.
2. instr=0x34088001 (ORI) -> imm32=0x00008001, sign_ext_o=0. Then instr=0x3C081234 (LUI) -> imm32=0x12340000.
3. Branch targets:
   - BEQ instr=0x1000FFFF, pc=0x00400010 -> is_branch=1, br_target=0x00400010.
   - BEQ instr=0x10000000, pc=0xFFFFFFFC -> br_target=0x00000000 (wrap).
4. Back-pressure: feed 4 back-to-back ADDIs (imm 1,2,3,4) with out_ready=0 -> in_ready=0 after 2 accepts, outputs held. Raise out_ready -> results 1,2,3,4 in order, no loss or duplicate, retired=4.
5. flush with 2 entries in flight plus in_valid=1 -> out_valid=0 next cycle, no later output from those 3 instructions, retired unchanged.
6. Async rst pulse mid-stream (not on an edge) -> all outputs 0 immediately. Resume after release with instr=0xFC000000 -> illegal=1, imm32=0.
